// File: rtl/sk6812_rx.sv
// sk6812_rx -- one-wire SK6812/WS2812 NRZ pulse-width decoder.
//
// Recovers MSB-first pixel words from the LED data line, detects the latch
// gap that closes a frame and flags protocol errors (overlong high, or a
// pixel truncated by the gap). Pulses shorter than MIN_HIGH_CYC are treated
// as glitches and ignored.
//
// Optional build macro: SK6812_RX_FORWARD_EN
//   When defined, the block behaves as a daisy-chained LED. It keeps the first
//   pixel of each frame and regenerates the rest of the bits on dout.
//   When undefined, dout is tied low and every pixel is reported.
//
// Ports:
//   sys_clk    in   system clock (50 MHz nominal)
//   sys_rst    in   synchronous reset, active-high
//   din        in   LED data line, asynchronous to sys_clk
//   pix_data   out  last decoded pixel word, first received bit in the MSB
//   pix_valid  out  pix_data holds an unconsumed pixel
//   pix_ready  in   consumer accepts pix_data when pix_valid & pix_ready
//   pix_count  out  pixels completed in the current frame, saturating
//   frame_end  out  one-cycle pulse when a latch gap closes a frame
//   overrun    out  one-cycle pulse when a pixel is dropped because the
//                   held pixel was still unconsumed
//   proto_err  out  one-cycle pulse on an overlong high or a truncated pixel
//   dout       out  regenerated forward output
module sk6812_rx #(
  parameter int BITS_PER_PIX    = 32,
  parameter int MIN_HIGH_CYC    = 4,
  parameter int HIGH_THRESH_CYC = 23,
  parameter int MAX_HIGH_CYC    = 60,
  parameter int RESET_CYC       = 4000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    din,
  output logic [BITS_PER_PIX-1:0] pix_data,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [15:0]             pix_count,
  output logic                    frame_end,
  output logic                    overrun,
  output logic                    proto_err,
  output logic                    dout
);

  localparam int LW = $clog2(RESET_CYC + 1);
  localparam int HW = $clog2(MAX_HIGH_CYC + 2);
  localparam int BW = $clog2(BITS_PER_PIX + 1);

  localparam logic [LW-1:0] L_GAP  = LW'(RESET_CYC);
  localparam logic [HW-1:0] H_MIN  = HW'(MIN_HIGH_CYC);
  localparam logic [HW-1:0] H_THR  = HW'(HIGH_THRESH_CYC);
  localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH_CYC);
  localparam logic [BW-1:0] B_FULL = BW'(BITS_PER_PIX);

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t                  state;
  logic                    din_m, din_s, din_d;
  logic [LW-1:0]           lcnt;
  logic [LW-1:0]           lcnt_inc;
  logic [HW-1:0]           hcnt;
  logic [BW-1:0]           bitcnt;
  logic [BITS_PER_PIX-1:0] shreg;
  logic                    prev_low;   // low state to resume after a glitch
  logic                    seen_bits;  // a bit was decoded since the last gap
  logic                    rise;
  logic                    hbit;
  logic                    fwd_on;     // first pixel of the frame is taken

`ifdef SK6812_RX_FORWARD_EN
  localparam logic [4:0] FWD_LEN0 = 5'd15;
  localparam logic [4:0] FWD_LEN1 = 5'd30;
  logic [4:0] fwd_cnt;
`else
  assign dout   = 1'b0;
  assign fwd_on = 1'b0;
`endif

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  assign rise     = din_s & ~din_d;
  assign hbit     = (hcnt >= H_THR);
  assign lcnt_inc = (lcnt == L_GAP) ? lcnt : lcnt + 1'b1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= WAIT_GAP;
      lcnt      <= '0;
      hcnt      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      prev_low  <= 1'b0;
      seen_bits <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_count <= '0;
      frame_end <= 1'b0;
      overrun   <= 1'b0;
      proto_err <= 1'b0;
`ifdef SK6812_RX_FORWARD_EN
      fwd_on    <= 1'b0;
      fwd_cnt   <= '0;
      dout      <= 1'b0;
`endif
    end else begin
      frame_end <= 1'b0;
      overrun   <= 1'b0;
      proto_err <= 1'b0;

      if (pix_valid && pix_ready)
        pix_valid <= 1'b0;

`ifdef SK6812_RX_FORWARD_EN
      // The regenerated pulse runs for fwd_cnt+1 cycles after launch.
      if (fwd_cnt != '0)
        fwd_cnt <= fwd_cnt - 1'b1;
      else
        dout <= 1'b0;
`endif

      case (state)
        WAIT_GAP: begin
          if (din_s) begin
            lcnt <= '0;
          end else begin
            lcnt <= lcnt_inc;
            if (lcnt_inc == L_GAP) begin
              state     <= IDLE;
              seen_bits <= 1'b0;
`ifdef SK6812_RX_FORWARD_EN
              fwd_on    <= 1'b0;
`endif
            end
          end
        end

        IDLE: begin
          if (rise) begin
            state    <= HIGH;
            hcnt     <= 1'b1;  // the rising-edge cycle counts as high time
            prev_low <= 1'b0;
          end
        end

        HIGH: begin
          if (hcnt > H_MAX) begin
            proto_err <= 1'b1;
            bitcnt    <= '0;
            lcnt      <= '0;
            state     <= WAIT_GAP;
          end else if (!din_s) begin
            if (hcnt < H_MIN) begin
              // Glitch: resume the low state without touching lcnt.
              state <= prev_low ? LOW : IDLE;
            end else begin
              seen_bits <= 1'b1;
              lcnt      <= '0;
              state     <= LOW;
              if (!fwd_on) begin
                shreg  <= {shreg[BITS_PER_PIX-2:0], hbit};
                bitcnt <= bitcnt + 1'b1;
              end
`ifdef SK6812_RX_FORWARD_EN
              else begin
                dout    <= 1'b1;
                fwd_cnt <= (hbit ? FWD_LEN1 : FWD_LEN0) - 1'b1;
              end
`endif
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        LOW: begin
          if (din_s) begin
            state    <= HIGH;
            hcnt     <= 1'b1;
            prev_low <= 1'b1;
          end else begin
            lcnt <= lcnt_inc;
            if (lcnt_inc == L_GAP) begin
              if (bitcnt != '0) begin
                proto_err <= 1'b1;
                bitcnt    <= '0;
              end
              frame_end <= seen_bits;
              seen_bits <= 1'b0;
              pix_count <= '0;
              state     <= IDLE;
`ifdef SK6812_RX_FORWARD_EN
              fwd_on    <= 1'b0;
`endif
            end
          end
        end

        default: state <= WAIT_GAP;
      endcase

      // Completion runs the cycle after the last shift. The FSM is then in
      // LOW with a tiny lcnt, so it cannot collide with the gap or error
      // paths above.
      if (bitcnt == B_FULL) begin
        bitcnt <= '0;
        if (pix_count != '1)
          pix_count <= pix_count + 1'b1;
        if (!pix_valid || pix_ready) begin
          pix_data  <= shreg;
          pix_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
`ifdef SK6812_RX_FORWARD_EN
        fwd_on <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sk6812_rx.sv
// tb_sk6812_rx -- directed bench for sk6812_rx.
// Drives NRZ bit slots of 62 cycles, with 15-cycle highs for '0' and 30-cycle
// highs for '1'. Monitors count the output pulses and handshakes, and every
// check compares against hand-computed values.
module tb_sk6812_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        din;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_count;
  logic        frame_end;
  logic        overrun;
  logic        proto_err;
  logic        dout;

  sk6812_rx #(
    .BITS_PER_PIX   (32),
    .MIN_HIGH_CYC   (4),
    .HIGH_THRESH_CYC(23),
    .MAX_HIGH_CYC   (60),
    .RESET_CYC      (4000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .din      (din),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_count(pix_count),
    .frame_end(frame_end),
    .overrun  (overrun),
    .proto_err(proto_err),
    .dout     (dout)
  );

  always #10 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Output monitors, sampled on the falling edge.
  int          fe_n = 0, pe_n = 0, ov_n = 0, pv_n = 0, acc_n = 0, dhi_n = 0;
  int          dcur = 0;
  int          widths[$];
  logic [31:0] acc_word = '0;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (frame_end) fe_n <= fe_n + 1;
      if (proto_err) pe_n <= pe_n + 1;
      if (overrun)   ov_n <= ov_n + 1;
      if (pix_valid) pv_n <= pv_n + 1;
      if (pix_valid && pix_ready) begin
        acc_n    <= acc_n + 1;
        acc_word <= pix_data;
      end
      if (dout) begin
        dhi_n <= dhi_n + 1;
        dcur  <= dcur + 1;
      end else if (dcur != 0) begin
        widths.push_back(dcur);
        dcur <= 0;
      end
    end
  end

  int s_fe, s_pe, s_ov, s_pv, s_acc;

  task automatic snap();
    s_fe  = fe_n;
    s_pe  = pe_n;
    s_ov  = ov_n;
    s_pv  = pv_n;
    s_acc = acc_n;
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Send the top n bits of w, MSB first. The bit at glitch_at gets a 2-cycle
  // glitch in its low phase, and the bit at long_at is a 70-cycle high.
  task automatic send_bits(input logic [31:0] w, input int n,
                           input int glitch_at, input int long_at);
    logic [31:0] v;
    logic        b;
    int          hi;
    v = w;
    for (int i = 0; i < n; i++) begin
      b  = v[31-i];
      hi = b ? 30 : 15;
      if (i == long_at) begin
        hold(1'b1, 70);
        hold(1'b0, 20);
      end else if (i == glitch_at) begin
        hold(1'b1, hi);
        hold(1'b0, 20);
        hold(1'b1, 2);
        hold(1'b0, 62 - hi - 22);
      end else begin
        hold(1'b1, hi);
        hold(1'b0, 62 - hi);
      end
    end
  endtask

  task automatic send_pix(input logic [31:0] w);
    send_bits(w, 32, -1, -1);
  endtask

`ifdef SK6812_RX_FORWARD_EN
  logic [63:0] fwd_bits;
  logic        fb;
`endif

  initial begin
    sys_rst   = 1'b1;
    din       = 1'b0;
    pix_ready = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    check("rst_valid", {31'b0, pix_valid}, 32'd0);
    check("rst_data",  pix_data, 32'd0);
    check("rst_count", {16'b0, pix_count}, 32'd0);
    check("rst_pulses", {29'b0, frame_end, overrun, proto_err}, 32'd0);
    check("rst_dout",  {31'b0, dout}, 32'd0);
    sys_rst = 1'b0;
    hold(1'b0, 4100);

`ifdef SK6812_RX_FORWARD_EN
    // Three pixels: keep the first, regenerate the other 64 bits on dout.
    snap();
    send_pix(32'hA1B2C3D4);
    send_pix(32'h0F0F55AA);
    send_pix(32'hF0E1D2C3);
    check("fwd_data",  pix_data, 32'hA1B2C3D4);
    check("fwd_acc",   acc_n - s_acc, 1);
    check("fwd_word",  acc_word, 32'hA1B2C3D4);
    check("fwd_count", {16'b0, pix_count}, 32'd1);
    hold(1'b0, 4100);
    check("fwd_fe",     fe_n - s_fe, 1);
    check("fwd_pe",     pe_n - s_pe, 0);
    check("fwd_npulse", widths.size(), 64);
    fwd_bits = {32'h0F0F55AA, 32'hF0E1D2C3};
    for (int i = 0; i < 64 && i < widths.size(); i++) begin
      fb = fwd_bits[63-i];
      check("fwd_width", widths[i], fb ? 32'd30 : 32'd15);
    end
`else
    // 1: single pixel, always ready, then the gap.
    snap();
    send_pix(32'hFF00A55A);
    check("t1_acc",   acc_n - s_acc, 1);
    check("t1_vcyc",  pv_n - s_pv, 1);
    check("t1_word",  acc_word, 32'hFF00A55A);
    check("t1_count", {16'b0, pix_count}, 32'd1);
    hold(1'b0, 4100);
    check("t1_fe",    fe_n - s_fe, 1);
    check("t1_pe",    pe_n - s_pe, 0);
    check("t1_count0", {16'b0, pix_count}, 32'd0);

    // 2: two pixels with no consumer, then release.
    pix_ready = 1'b0;
    snap();
    send_pix(32'h12345678);
    send_pix(32'h9ABCDEF0);
    check("t2_valid", {31'b0, pix_valid}, 32'd1);
    check("t2_hold",  pix_data, 32'h12345678);
    check("t2_ovr",   ov_n - s_ov, 1);
    check("t2_count", {16'b0, pix_count}, 32'd2);
    pix_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    check("t2_drop",  {31'b0, pix_valid}, 32'd0);
    check("t2_acc",   acc_n - s_acc, 1);
    check("t2_word",  acc_word, 32'h12345678);
    hold(1'b0, 4100);
    check("t2_fe",    fe_n - s_fe, 1);

    // 3: truncated pixel of 10 bits.
    snap();
    send_bits(32'hABCDEF01, 10, -1, -1);
    hold(1'b0, 4100);
    check("t3_pe",    pe_n - s_pe, 1);
    check("t3_vcyc",  pv_n - s_pv, 0);
    check("t3_fe",    fe_n - s_fe, 1);
    check("t3_count", {16'b0, pix_count}, 32'd0);

    // 4a: a glitch in the low phase is ignored.
    snap();
    send_bits(32'h0F0F3C3C, 32, 5, -1);
    check("t4_gacc",  acc_n - s_acc, 1);
    check("t4_gword", acc_word, 32'h0F0F3C3C);
    check("t4_gpe",   pe_n - s_pe, 0);
    // 4b: an overlong high aborts; the remaining bits stay undecoded.
    snap();
    send_bits(32'h76543210, 32, -1, 3);
    check("t4_lpe",   pe_n - s_pe, 1);
    check("t4_lacc",  acc_n - s_acc, 0);
    hold(1'b0, 4100);
    check("t4_lfe",   fe_n - s_fe, 0);
    snap();
    send_pix(32'hC3C3A5A5);
    check("t4_racc",  acc_n - s_acc, 1);
    check("t4_rword", acc_word, 32'hC3C3A5A5);
    hold(1'b0, 4100);
    check("t4_rfe",   fe_n - s_fe, 1);

    // 5: reset partway through a pixel.
    snap();
    send_bits(32'hDEADBEEF, 20, -1, -1);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("t5_rcount", {16'b0, pix_count}, 32'd0);
    check("t5_rvalid", {31'b0, pix_valid}, 32'd0);
    send_pix(32'h11223344);
    check("t5_nvcyc", pv_n - s_pv, 0);
    hold(1'b0, 4100);
    check("t5_fe0",   fe_n - s_fe, 0);
    send_pix(32'h5AA5F00F);
    check("t5_acc",   acc_n - s_acc, 1);
    check("t5_word",  acc_word, 32'h5AA5F00F);
    check("t5_count", {16'b0, pix_count}, 32'd1);
    check("t5_pe",    pe_n - s_pe, 0);
    hold(1'b0, 4100);
    check("t5_fe",    fe_n - s_fe, 1);

    check("dout_low", dhi_n, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
